// File: rtl/uart_pkg.sv
// Shared register map, bit positions and FSM state types for uart_ctl.
package uart_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_CTRL   = 4'd2;
  localparam logic [3:0] ADDR_DIV    = 4'd3;

  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  localparam int CT_RX_IE  = 0;
  localparam int CT_TX_IE  = 1;
  localparam int CT_ERR_IE = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO: dout is the head entry with no read latency.
// A push into a full FIFO is accepted only when a pop frees a slot that same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; validity is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_ctl.sv
// 8N1 UART with TX/RX FIFOs, programmable bit divisor and a level interrupt,
// attached to the 4-bit-address / 16-bit-data io bus.
module uart_ctl
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [3:0]  io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        uart_intr,
  output logic        tx,
  input  logic        rx
);

  logic        wr_data, wr_status, wr_ctrl, wr_div, rd_pop;
  logic [2:0]  ctrl_q;
  logic [15:0] div_q;
  logic        overrun_q, frame_err_q;

  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;
  logic [7:0] rx_head;
  logic       rx_avail, tx_idle, overrun_set, ferr_set;

  assign wr_data   = io_write && (io_addr == ADDR_DATA);
  assign wr_status = io_write && (io_addr == ADDR_STATUS);
  assign wr_ctrl   = io_write && (io_addr == ADDR_CTRL);
  assign wr_div    = io_write && (io_addr == ADDR_DIV);
  assign rd_pop    = io_read  && (io_addr == ADDR_DATA);

  // ---------------- FIFOs ----------------
  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data && !tx_full),
    .pop   (tx_pop),
    .din   (io_wdata[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  logic [7:0] rx_shift_q;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rd_pop),
    .din   (rx_shift_q),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // ---------------- Transmitter ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_tick;

  assign tx_tick = (tx_cnt_q == 16'd0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = div_q;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_cnt_d   = div_q;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = div_q;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          // Back-to-back frames: a waiting byte starts with no idle gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_cnt_d   = div_q;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
    endcase
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

  // ---------------- Receiver ----------------
  logic        rx_s1, rx_s2, rx_prev;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_half;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_d;
  logic        rx_brk_q, rx_brk_d, rx_tick;

  assign rx_half = {1'b0, div_q[15:1]};
  assign rx_tick = (rx_cnt_q == 16'd0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          // The edge cycle is sample offset 0; a zero half-bit means the start bit is already confirmed.
          if (rx_half == 16'd0) begin
            rx_cnt_d   = div_q;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end else begin
            rx_cnt_d   = rx_half - 16'd1;
            rx_state_d = RX_START;
          end
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_s2) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = div_q;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_s2, rx_shift_q[7:1]};
          rx_cnt_d   = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_brk_q) begin
          // Line held low after a bad stop bit: wait for it to rise before rearming.
          if (rx_s2) begin
            rx_brk_d   = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (rx_tick) begin
          rx_push = 1'b1;
          if (rx_s2) begin
            rx_state_d = RX_IDLE;
          end else begin
            ferr_set = 1'b1;
            rx_brk_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  // ---------------- Registers and status ----------------
  assign overrun_set = rx_push && rx_full && !rd_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      div_q       <= DIV_RESET;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= io_wdata[2:0];
      if (wr_div)  div_q  <= io_wdata;
      // A new error in the same cycle as a write-clear keeps the flag set.
      if (overrun_set)                             overrun_q <= 1'b1;
      else if (wr_status && io_wdata[ST_RX_OVERRUN]) overrun_q <= 1'b0;
      if (ferr_set)                                frame_err_q <= 1'b1;
      else if (wr_status && io_wdata[ST_FRAME_ERR])  frame_err_q <= 1'b0;
    end
  end

  assign rx_avail = !rx_empty;
  assign tx_idle  = tx_empty && (tx_state_q == TX_IDLE);

  logic [15:0] status_word;

  always_comb begin
    status_word                = '0;
    status_word[ST_RX_AVAIL]   = rx_avail;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_TX_IDLE]    = tx_idle;
    status_word[ST_RX_OVERRUN] = overrun_q;
    status_word[ST_FRAME_ERR]  = frame_err_q;
  end

  always_comb begin
    io_rdata = 'x;
    case (io_addr)
      ADDR_DATA:   io_rdata = {7'h0, rx_avail, rx_head};
      ADDR_STATUS: io_rdata = status_word;
      ADDR_CTRL:   io_rdata = {13'h0, ctrl_q};
      ADDR_DIV:    io_rdata = div_q;
      default:     io_rdata = 'x;
    endcase
  end

  assign uart_intr = (ctrl_q[CT_RX_IE]  && rx_avail)
                   | (ctrl_q[CT_TX_IE]  && tx_empty)
                   | (ctrl_q[CT_ERR_IE] && (overrun_q || frame_err_q));

endmodule

// File: doc/uart_ctl.md
Name: uart_ctl

Overview:
- Byte-wide UART that sits directly upstream of the interrupt controller and drives its uart_intr input.
- Software reaches it over the shared 4-bit-address, 16-bit-data io bus.
- Contains an 8N1 transmitter and receiver, an 8-entry TX FIFO and an 8-entry RX FIFO, and a programmable bit-time divisor.
- uart_intr is a level output; it is cleared only by servicing the condition that raised it.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; must be a power of 2, ≥2.
- DIV_RESET, 16'd433, divisor value loaded at reset; bit time = DIV+1 clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- io_write  in  1  write strobe, 1 cycle per access.
- io_read  in  1  read strobe; only used to pop the RX FIFO.
- io_addr  in  4  register select.
- io_wdata  in  16  write data.
- io_rdata  out  16  combinational read data.
- uart_intr  out  1  level interrupt to the interrupt controller.
- tx  out  1  serial out; idles high.
- rx  in  1  serial in; asynchronous.

Behaviour:
- Register map (io_rdata is combinational from io_addr; unmapped addresses read 16'hx):
  - 0 DATA. Write pushes io_wdata[7:0] to the TX FIFO. Read returns {7'h0, rx_avail, rx_head[7:0]}. Read with io_read pops the RX FIFO if it is non-empty.
  - 1 STATUS. Bits: [0] rx_avail, [1] tx_full, [2] tx_idle (TX FIFO empty AND shifter idle), [3] rx_overrun (sticky), [4] frame_err (sticky). Writing 1 to bit 3 or bit 4 clears that bit.
  - 2 CTRL. Bits: [0] rx_ie, [1] tx_ie, [2] err_ie. Reset value 0.
  - 3 DIV. 16-bit divisor, reset to DIV_RESET. A new value takes effect at the next bit boundary; no partial bit is shortened.
- uart_intr = (rx_ie & rx_avail) | (tx_ie & tx FIFO empty) | (err_ie & (rx_overrun | frame_err)).
- Reset values: tx=1, uart_intr=0, both FIFOs empty, sticky flags 0, TX and RX FSMs IDLE. Reset in mid-frame aborts the frame and drives tx high on the next edge.
- TX FSM, states IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE:
  - In IDLE with the FIFO non-empty: pop the FIFO and enter START on the next edge.
  - A DATA write at cycle N to an empty FIFO with an idle shifter gives tx=0 from cycle N+2.
  - Each state holds for DIV+1 cycles.
  - At the end of STOP: if the FIFO is non-empty, go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- TX FIFO full: a DATA write is silently dropped and the FIFO is unchanged.
- RX input: rx passes through a 2-flop synchroniser. RX FSM, states IDLE → START → DATA → STOP:
  - IDLE detects a synchronised falling edge.
  - START waits DIV/2 cycles (floor) and resamples. If the line is back high, it is a glitch: return to IDLE. Otherwise each data bit is sampled DIV+1 cycles after the previous sample.
  - STOP samples the stop bit. If it is 0, set frame_err but still push the byte. The FSM returns to IDLE only after rx is seen high, so a break does not retrigger.
- RX push when the FIFO is full: the byte is dropped and rx_overrun is set. Exception: a pop in the same cycle makes room, so the push succeeds and no overrun is flagged.
- Write-clear of a sticky flag in the same cycle as a new set: the set wins.
- Divisor counter is 16-bit and reloads with DIV at every bit boundary. DIV=0 gives 1-cycle bits; RX still samples at offset 0.

Decomposition:
- uart_pkg holds:
  - register address constants (DATA=0, STATUS=1, CTRL=2, DIV=3);
  - STATUS/CTRL bit-index constants;
  - the tx_state_t and rx_state_t enums.
- Sub-module uart_fifo: synchronous FIFO.
  - Parameters WIDTH=8 and DEPTH.
  - Interface: push/pop/din/dout/full/empty. dout shows the head entry with no read latency.
  - Used once for TX and once for RX.

Test Plan:
- Reset, then read regs 1/2/3 → STATUS=16'h0004, CTRL=0, DIV=433; tx=1; uart_intr=0.
- DIV=3, write DATA=8'hA5 at cycle N → tx=0 for cycles N+2..N+5. Then data bits 1,0,1,0,0,1,0,1 with 4 cycles each, then stop high. tx_idle returns to 1 after 40 cycles.
- DIV=3, tx looped to rx, write 8'h3C, 8'hC3 back-to-back → rx_avail=1; two DATA reads with io_read return 8'h3C then 8'hC3; then rx_avail=0.
- Loopback, 9 bytes received with no pops → FIFO holds the first 8 bytes, rx_overrun=1. With err_ie=1, uart_intr=1. Writing STATUS=16'h0008 clears it and uart_intr falls next cycle.
- Drive rx with start bit, 8'h00 and stop bit=0 → byte 8'h00 is pushed and frame_err=1. rx is held low for 3 more frames and no further bytes are received until rx goes high.
- tx_ie=1 with empty FIFO → uart_intr=1. Write 9 bytes while the shifter is busy → 9th dropped, tx_full=1, uart_intr=0 until the FIFO drains; reset mid-frame → tx=1 next cycle.
